// File: rtl/mem_cache_ctrl.sv
// Memory-stage cache controller: 2-way set-associative, write-through,
// no-write-allocate, 64 sets of 64-bit blocks in front of a slow SRAM.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | serve read hits, launch SRAM block read or word write
// S_RMISS | waiting for SRAM block, fill victim way on sram_ready
// S_WRITE | waiting for SRAM write ack, update cached word on a hit
module mem_cache_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic [31:0] data,
    input  logic        MEM_R_en,
    input  logic        MEM_W_en,
    output logic [31:0] rdata,
    output logic        ready,
    output logic [31:0] sram_address,
    output logic [31:0] sram_wdata,
    output logic        sram_read,
    output logic        sram_write,
    input  logic [63:0] sram_rdata,
    input  logic        sram_ready
);

    typedef enum logic [1:0] {S_IDLE, S_RMISS, S_WRITE} state_t;

    state_t      state, state_nxt;

    logic [63:0] valid0, valid1, lru;
    logic [9:0]  tag0 [64];
    logic [9:0]  tag1 [64];
    logic [63:0] blk0 [64];
    logic [63:0] blk1 [64];

    logic [5:0]  idx;
    logic [9:0]  tag_in;
    logic        word_sel;
    logic        hit0, hit1, hit;
    logic [63:0] hit_blk, merged_blk;
    logic        victim;
    logic        touch, fill, wupd;

    assign idx      = address[8:3];
    assign tag_in   = address[18:9];
    assign word_sel = address[2];

    // way0 takes precedence if both ways would match
    assign hit0    = valid0[idx] && (tag0[idx] == tag_in);
    assign hit1    = valid1[idx] && (tag1[idx] == tag_in) && !hit0;
    assign hit     = hit0 || hit1;
    assign hit_blk = hit0 ? blk0[idx] : blk1[idx];

    // store data merged into the addressed word of the hit block
    assign merged_blk = word_sel ? {data, hit_blk[31:0]} : {hit_blk[63:32], data};

    // first invalid way, else the way marked for replacement
    assign victim = !valid0[idx] ? 1'b0 : (!valid1[idx] ? 1'b1 : lru[idx]);

    // next state, handshake outputs and array update strobes
    always_comb begin
        state_nxt    = state;
        ready        = 1'b1;
        rdata        = '0;
        sram_address = '0;
        sram_wdata   = '0;
        sram_read    = 1'b0;
        sram_write   = 1'b0;
        touch        = 1'b0;
        fill         = 1'b0;
        wupd         = 1'b0;
        case (state)
            S_IDLE: begin
                if (MEM_W_en) begin
                    ready        = 1'b0;
                    sram_write   = 1'b1;
                    sram_address = address;
                    sram_wdata   = data;
                    state_nxt    = S_WRITE;
                end else if (MEM_R_en) begin
                    if (hit) begin
                        rdata = word_sel ? hit_blk[63:32] : hit_blk[31:0];
                        touch = 1'b1;
                    end else begin
                        ready        = 1'b0;
                        sram_read    = 1'b1;
                        sram_address = {address[31:3], 3'b000};
                        state_nxt    = S_RMISS;
                    end
                end
            end
            S_RMISS: begin
                sram_read    = 1'b1;
                sram_address = {address[31:3], 3'b000};
                ready        = sram_ready;
                if (sram_ready) begin
                    rdata     = word_sel ? sram_rdata[63:32] : sram_rdata[31:0];
                    fill      = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_WRITE: begin
                sram_write   = 1'b1;
                sram_address = address;
                sram_wdata   = data;
                ready        = sram_ready;
                if (sram_ready) begin
                    wupd      = hit;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // state, valid and replacement bits; reset abandons any SRAM transaction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            valid0 <= '0;
            valid1 <= '0;
            lru    <= '0;
        end else begin
            state <= state_nxt;
            if (fill) begin
                if (victim) valid1[idx] <= 1'b1;
                else        valid0[idx] <= 1'b1;
                lru[idx] <= ~victim;
            end else if (touch || wupd) begin
                lru[idx] <= hit0;
            end
        end
    end

    // tag and block storage, not reset
    always_ff @(posedge clk) begin
        if (fill) begin
            if (victim) begin
                tag1[idx] <= tag_in;
                blk1[idx] <= sram_rdata;
            end else begin
                tag0[idx] <= tag_in;
                blk0[idx] <= sram_rdata;
            end
        end else if (wupd) begin
            if (hit0) blk0[idx] <= merged_blk;
            else      blk1[idx] <= merged_blk;
        end
    end

endmodule
